// File: rtl/dmac_ahbl_regs_if.sv
// AHB-Lite responder-side bus bundle for the DMA controller register block.
interface dmac_ahbl_regs_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
        output HREADYOUT, HRDATA
    );
endinterface

// File: rtl/dmac_ahbl_regs.sv
// AHB-Lite register block for a single-channel DMA controller: config, start command, DONE flag.
// Define DMAC_REGS_IRQ_EN to build the IM register and the irq output.
module dmac_ahbl_regs (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    dmac_ahbl_regs_if.slave        ahb,
    output logic [31:0]            saddr,
    output logic [31:0]            daddr,
    output logic [2:0]             ssize,
    output logic [2:0]             dsize,
    output logic [2:0]             sinc,
    output logic [2:0]             dinc,
    output logic [7:0]             bsize,
    output logic [7:0]             bcount,
    output logic                   start,
    output logic                   wfi,
    output logic [2:0]             irqsrc,
    output logic [31:0]            icra,
    output logic [31:0]            icrv,
    input  logic                   done,
    input  logic                   busy,
    output logic                   irq
);
    localparam logic [5:0] OffSaddr  = 6'h00;
    localparam logic [5:0] OffDaddr  = 6'h01;
    localparam logic [5:0] OffCtrl   = 6'h02;
    localparam logic [5:0] OffSize   = 6'h03;
    localparam logic [5:0] OffWait   = 6'h04;
    localparam logic [5:0] OffIcra   = 6'h05;
    localparam logic [5:0] OffIcrv   = 6'h06;
    localparam logic [5:0] OffCmd    = 6'h07;
    localparam logic [5:0] OffStatus = 6'h08;
    localparam logic [5:0] OffIm     = 6'h09;

    logic       pend_q;
    logic       write_q;
    logic [5:0] addr_q;
    logic       done_flag;
    logic       im_en;
    logic       wr_en;
    logic       cfg_we;
    logic       start_set;
    logic [31:0] rdata;
    logic       unused_ahb;

    assign unused_ahb = ^{ahb.HSIZE, ahb.HADDR[31:8], ahb.HADDR[1:0], ahb.HTRANS[0]};

    assign wr_en     = pend_q & write_q;
    // Configuration is frozen while a transfer runs or is being launched.
    assign cfg_we    = wr_en & ~busy & ~start;
    assign start_set = wr_en & (addr_q == OffCmd) & ahb.HWDATA[0] & ~busy & ~start;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 6'h00;
        end else begin
            pend_q  <= ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
            write_q <= ahb.HWRITE;
            addr_q  <= ahb.HADDR[7:2];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            saddr  <= 32'h0;
            daddr  <= 32'h0;
            ssize  <= 3'h0;
            dsize  <= 3'h0;
            sinc   <= 3'h0;
            dinc   <= 3'h0;
            bsize  <= 8'h0;
            bcount <= 8'h0;
            wfi    <= 1'b0;
            irqsrc <= 3'h0;
            icra   <= 32'h0;
            icrv   <= 32'h0;
        end else if (cfg_we) begin
            case (addr_q)
                OffSaddr: saddr <= ahb.HWDATA;
                OffDaddr: daddr <= ahb.HWDATA;
                OffCtrl: begin
                    ssize <= ahb.HWDATA[2:0];
                    dsize <= ahb.HWDATA[6:4];
                    sinc  <= ahb.HWDATA[10:8];
                    dinc  <= ahb.HWDATA[14:12];
                end
                OffSize: begin
                    bsize  <= ahb.HWDATA[7:0];
                    bcount <= ahb.HWDATA[15:8];
                end
                OffWait: begin
                    wfi    <= ahb.HWDATA[0];
                    irqsrc <= ahb.HWDATA[6:4];
                end
                OffIcra: icra <= ahb.HWDATA;
                OffIcrv: icrv <= ahb.HWDATA;
                default: ;
            endcase
        end
    end

    // A completion pulse outranks both the start clear and a software W1C.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            start     <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            start <= start_set;
            if (done) begin
                done_flag <= 1'b1;
            end else if (start_set) begin
                done_flag <= 1'b0;
            end else if (wr_en && (addr_q == OffStatus) && ahb.HWDATA[1]) begin
                done_flag <= 1'b0;
            end
        end
    end

`ifdef DMAC_REGS_IRQ_EN
    logic im_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            im_q <= 1'b0;
        end else if (wr_en && (addr_q == OffIm)) begin
            im_q <= ahb.HWDATA[0];
        end
    end

    assign im_en = im_q;
    assign irq   = done_flag & im_q;
`else
    assign im_en = 1'b0;
    assign irq   = 1'b0;
`endif

    always_comb begin
        rdata = 32'h0;
        if (pend_q && !write_q) begin
            case (addr_q)
                OffSaddr:  rdata = saddr;
                OffDaddr:  rdata = daddr;
                OffCtrl:   rdata = {17'h0, dinc, 1'b0, sinc, 1'b0, dsize, 1'b0, ssize};
                OffSize:   rdata = {16'h0, bcount, bsize};
                OffWait:   rdata = {25'h0, irqsrc, 3'h0, wfi};
                OffIcra:   rdata = icra;
                OffIcrv:   rdata = icrv;
                OffStatus: rdata = {30'h0, done_flag, busy};
                OffIm:     rdata = {31'h0, im_en};
                default:   rdata = 32'h0;
            endcase
        end
    end

    assign ahb.HRDATA    = rdata;
    assign ahb.HREADYOUT = 1'b1;
endmodule

// File: doc/dmac_ahbl_regs.md
DMAC_AHBL_REGS -- requirements
Module: dmac_ahbl_regs

Interface
REQ-001 SHALL have ports: HCLK  in  1  clock; all logic on rising edge.
REQ-002 SHALL have ports: HRESETn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have AHB-Lite responder ports: HSEL in 1; HADDR in 32; HTRANS in 2; HSIZE in 3; HWRITE in 1; HREADY in 1 (bus-level); HWDATA in 32; HREADYOUT out 1; HRDATA out 32.
REQ-004 SHALL have DMA-side outputs: saddr 32; daddr 32; ssize 3; dsize 3; sinc 3; dinc 3; bsize 8; bcount 8; start 1; wfi 1; irqsrc 3; icra 32; icrv 32.
REQ-005 SHALL have DMA-side inputs: done 1 (one-cycle completion pulse); busy 1 (transfer in progress).
REQ-006 SHALL have output irq 1, the level interrupt to the system.

Function
REQ-007 SHALL capture a transfer in the address phase when HSEL & HTRANS[1] & HREADY; latch HADDR[7:2] and HWRITE; otherwise mark no pending transfer.
REQ-008 SHALL perform a pending write at the end of the following cycle (data phase) using HWDATA; HSIZE is ignored; all writes are full 32-bit.
REQ-009 SHALL drive HRDATA combinationally during the data phase from the register at the latched address; unmapped offsets read 0; HRDATA is 0 when no read is pending.
REQ-010 SHALL tie HREADYOUT to 1 (zero wait states); no error responses.
REQ-011 SHALL implement this register map (byte offsets):
 - 0x00 SADDR RW -> saddr; 0x04 DADDR RW -> daddr
 - 0x08 CTRL RW: [2:0] ssize, [6:4] dsize, [10:8] sinc, [14:12] dinc; other bits read 0
 - 0x0C SIZE RW: [7:0] bsize, [15:8] bcount
 - 0x10 WAIT RW: [0] wfi, [6:4] irqsrc
 - 0x14 ICRA RW -> icra; 0x18 ICRV RW -> icrv
 - 0x1C CMD WO: writing bit0=1 requests start; reads 0
 - 0x20 STATUS: [0] busy (RO, live input), [1] DONE flag (sticky, W1C)
 - 0x24 IM RW: [0] done-interrupt enable
REQ-012 SHALL ignore writes to 0x00-0x18 while busy=1 or start=1 (configuration lock); reads remain valid.
REQ-013 SHALL assert start for exactly one HCLK cycle, in the cycle after a CMD write data phase with bit0=1, only if busy=0 and start=0; otherwise the request is dropped.
REQ-014 SHALL set the DONE flag on the cycle after done=1; a W1C of bit1 in the same cycle as done=1 leaves the flag set (set wins).
REQ-015 SHALL clear the DONE flag on the cycle in which a start pulse is issued.
REQ-016 SHALL drive irq = DONE & IM[0], registered-free (combinational from flops).
REQ-017 SHALL honour back-to-back transfers: a read data phase immediately following a write data phase to the same offset returns the newly written value.
REQ-018 SHALL ignore writes to unmapped offsets and to the RO STATUS bit0.

Reset
REQ-019 SHALL, on HRESETn low, asynchronously clear all registers, the DONE flag, IM, the pending-transfer state and start to 0; HRDATA=0, irq=0, HREADYOUT=1.
REQ-020 SHALL, on reset during a data phase, discard the pending write.

Configuration
REQ-021 SHALL compile the interrupt logic only when DMAC_REGS_IRQ_EN is defined.
 - Defined: IM register present; irq per REQ-016.
 - Undefined: IM absent (offset 0x24 reads 0, writes ignored); irq tied 0; DONE flag still operates and is pollable.

Verification
REQ-022 Write 0x2000_0000 to 0x00, read 0x00 back-to-back -> HRDATA=0x2000_0000 in the read data phase; saddr=0x2000_0000.
REQ-023 With busy=0, write 1 to 0x1C -> start high for exactly 1 cycle; with busy=1, same write -> start stays 0.
REQ-024 With busy=1, write 0xFFFF to 0x0C -> bsize/bcount unchanged; after busy=0, same write -> bsize=0xFF, bcount=0xFF.
REQ-025 IM=1, pulse done -> STATUS reads 0x2, irq=1; W1C 0x2 to 0x20 -> irq=0; W1C coincident with done -> flag stays 1.
REQ-026 Assert HRESETn low mid write data phase to 0x04 -> daddr=0, start=0, irq=0; build without DMAC_REGS_IRQ_EN -> read 0x24 returns 0, irq always 0.
